// File: rtl/result_writeback.sv
// result_writeback
//   Write-side initiator toward the memory block. Takes 512-bit result lines from
//   the pipeline on a valid/ready port and buffers them in a small FIFO. It issues
//   one write per line at consecutive cache-line addresses starting at base_addr.
//   After the last line it writes one status line at base_addr + num_results.
//   Only one write is ever outstanding.
//
//   Ports
//     clk, rst            clock; asynchronous active-high reset
//     start               1-cycle job start, only sampled while idle
//     base_addr           first line address (latched on start)
//     num_results         number of result lines in the job (latched on start)
//     res_valid/res_data  result line input
//     res_ready           line accepted this cycle
//     write_request_valid 1-cycle write request pulse
//     address/write_data  request payload, held until write_done
//     write_done          memory completed the outstanding write
//     busy                job in progress
//     done                1-cycle pulse after the status write completes
//     lines_written       result lines completed in the current/last job
module result_writeback #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_results,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              write_request_valid,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic              write_done,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_written
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_STATUS_ISSUE,
        S_STATUS_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  acc_cnt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] status_word;

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign busy       = (state != S_IDLE);
    // Accept only while the job still owes lines; anything beyond num_results
    // is left on the input port.
    assign res_ready  = busy && !fifo_full && (acc_cnt < num_q);
    assign push       = res_valid && res_ready;
    // The head line is moved into write_data as FILL hands over to ISSUE.
    assign pop        = (state == S_FILL) && !fifo_empty;

    // Status line: completed count in the low bits, valid flag just above it.
    always_comb begin
        status_word             = '0;
        status_word[CNT_W-1:0]  = lines_written;
        status_word[CNT_W]      = 1'b1;
    end

    // Storage needs no reset; occupancy is tracked by the pointers below.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= res_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            base_q              <= '0;
            num_q               <= '0;
            acc_cnt             <= '0;
            lines_written       <= '0;
            address             <= '0;
            write_data          <= '0;
            write_request_valid <= 1'b0;
            done                <= 1'b0;
        end else begin
            if (push) acc_cnt <= acc_cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        num_q         <= num_results;
                        acc_cnt       <= '0;
                        lines_written <= '0;
                        state         <= (num_results == '0) ? S_STATUS_ISSUE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (!fifo_empty) begin
                        write_data          <= fifo_mem[rd_ptr];
                        address             <= base_q + ADDR_W'(lines_written);
                        write_request_valid <= 1'b1;
                        state               <= S_ISSUE;
                    end
                end
                // Request pulse is visible during this state only.
                S_ISSUE: begin
                    write_request_valid <= 1'b0;
                    state               <= S_WAIT;
                end
                S_WAIT: begin
                    if (write_done) begin
                        lines_written <= lines_written + CNT_W'(1);
                        state <= ((lines_written + CNT_W'(1)) == num_q) ? S_STATUS_ISSUE : S_FILL;
                    end
                end
                S_STATUS_ISSUE: begin
                    address             <= base_q + ADDR_W'(num_q);
                    write_data          <= status_word;
                    write_request_valid <= 1'b1;
                    state               <= S_STATUS_WAIT;
                end
                S_STATUS_WAIT: begin
                    write_request_valid <= 1'b0;
                    if (write_done && !write_request_valid) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
